// File: rtl/alu16_pkg.sv
// Shared opcodes and width for the alu16 execution unit.
// Optional flag outputs Z/V are enabled with macro ALU16_FLAGS_EN.
package alu16_pkg;

   localparam int ALU16_WIDTH = 16;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

endpackage

// File: rtl/alu16_addsub.sv
// Combinational adder/subtractor shared by ADD and SUB.
// Subtraction adds ~b and ~c_in, so the raw carry is an inverted borrow.
module alu16_addsub #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   logic [WIDTH-1:0] b_op;
   logic             c_op;
   logic [WIDTH:0]   full;

   assign b_op = sub ? ~b : b;
   assign c_op = sub ? ~c_in : c_in;
   assign full = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, c_op};

   assign sum   = full[WIDTH-1:0];
   assign c_out = full[WIDTH] ^ sub;

endmodule

// File: rtl/alu16.sv
// 8-operation ALU with 1-cycle registered result and carry.
// Define ALU16_FLAGS_EN to add registered zero (Z) and overflow (V) outputs.
module alu16
   import alu16_pkg::*;
#(
   parameter int WIDTH = ALU16_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       Mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C_in,
   output logic [WIDTH-1:0] X,
`ifdef ALU16_FLAGS_EN
   output logic             Z,
   output logic             V,
`endif
   output logic             C_out
);

   logic             is_sub;
   logic [WIDTH-1:0] as_sum;
   logic             as_c;
   logic [WIDTH-1:0] x_nxt;
   logic             c_nxt;

   assign is_sub = (Mode == OP_SUB);

   alu16_addsub #(
      .WIDTH (WIDTH)
   ) u_addsub (
      .a     (A),
      .b     (B),
      .c_in  (C_in),
      .sub   (is_sub),
      .sum   (as_sum),
      .c_out (as_c)
   );

   always_comb begin
      x_nxt = '0;
      c_nxt = 1'b0;
      unique case (Mode)
         OP_ADD, OP_SUB: begin
            x_nxt = as_sum;
            c_nxt = as_c;
         end
         OP_AND: x_nxt = A & B;
         OP_OR:  x_nxt = A | B;
         OP_XOR: x_nxt = A ^ B;
         OP_NOT: x_nxt = ~A;
         OP_SHL: begin
            x_nxt = {A[WIDTH-2:0], C_in};
            c_nxt = A[WIDTH-1];
         end
         OP_SHR: begin
            x_nxt = {C_in, A[WIDTH-1:1]};
            c_nxt = A[0];
         end
         default: begin
            x_nxt = '0;
            c_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         X     <= '0;
         C_out <= 1'b0;
      end else begin
         X     <= x_nxt;
         C_out <= c_nxt;
      end
   end

`ifdef ALU16_FLAGS_EN
   logic b_sgn;
   logic v_nxt;

   // SUB overflow uses the sign of the inverted B actually fed to the adder
   assign b_sgn = is_sub ? ~B[WIDTH-1] : B[WIDTH-1];
   assign v_nxt = ((Mode == OP_ADD) || is_sub)
                  && (A[WIDTH-1] == b_sgn)
                  && (as_sum[WIDTH-1] != A[WIDTH-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         Z <= 1'b0;
         V <= 1'b0;
      end else begin
         Z <= (x_nxt == '0);
         V <= v_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_alu16.sv
// Self-checking bench for alu16: directed vector table,
// hand sequences for reset, and random ops against an arithmetic model.
module tb_alu16;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  mode;
   logic [15:0] a, b;
   logic        c_in;
   logic [15:0] x;
   logic        c_out;
`ifdef ALU16_FLAGS_EN
   logic        z, v;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu16 dut (
      .clk   (clk),
      .rst   (rst),
      .Mode  (mode),
      .A     (a),
      .B     (b),
      .C_in  (c_in),
      .X     (x),
`ifdef ALU16_FLAGS_EN
      .Z     (z),
      .V     (v),
`endif
      .C_out (c_out)
   );

   typedef struct {
      logic [2:0]  m;
      logic [15:0] a;
      logic [15:0] b;
      logic        ci;
      logic [15:0] x;
      logic        c;
   } vec_t;

   vec_t tv [16];

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Reference model written with plain integer arithmetic
   task automatic model(input logic [2:0] m, input logic [15:0] ia,
                        input logic [15:0] ib, input logic ci,
                        output logic [15:0] ex, output logic ec,
                        output logic ez, output logic ev);
      int ua, ub, uc, r, sa, sb, s;
      ua = int'(ia);
      ub = int'(ib);
      uc = ci ? 1 : 0;
      sa = (ua >= 32768) ? ua - 65536 : ua;
      sb = (ub >= 32768) ? ub - 65536 : ub;
      r  = 0;
      ec = 1'b0;
      ev = 1'b0;
      case (m)
         3'd0: begin
            r  = ua + ub + uc;
            ec = (r > 65535);
            s  = sa + sb + uc;
            ev = (s > 32767) || (s < -32768);
         end
         3'd1: begin
            r  = ua - ub - uc;
            ec = (r < 0);
            s  = sa - sb - uc;
            ev = (s > 32767) || (s < -32768);
         end
         3'd2: r = ua & ub;
         3'd3: r = ua | ub;
         3'd4: r = ua ^ ub;
         3'd5: r = 65535 - ua;
         3'd6: begin
            r  = ua * 2 + uc;
            ec = (ua >= 32768);
         end
         default: begin
            r  = ua / 2 + uc * 32768;
            ec = (ua % 2) == 1;
         end
      endcase
      ex = 16'(r & 32'hFFFF);
      ez = (ex == 16'h0000);
   endtask

   task automatic drive(input logic r, input logic [2:0] m,
                        input logic [15:0] ia, input logic [15:0] ib,
                        input logic ci);
      rst  = r;
      mode = m;
      a    = ia;
      b    = ib;
      c_in = ci;
      @(posedge clk);
      #1;
   endtask

   logic [15:0] ex;
   logic        ec, ez, ev;
   logic        r_rand;

   initial begin
      tv[0]  = '{3'd0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
      tv[1]  = '{3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      tv[2]  = '{3'd0, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1};
      tv[3]  = '{3'd1, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0};
      tv[4]  = '{3'd1, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1};
      tv[5]  = '{3'd1, 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1};
      tv[6]  = '{3'd2, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b0};
      tv[7]  = '{3'd3, 16'hF0F0, 16'hFF00, 1'b1, 16'hFFF0, 1'b0};
      tv[8]  = '{3'd4, 16'hF0F0, 16'hFF00, 1'b1, 16'h0FF0, 1'b0};
      tv[9]  = '{3'd5, 16'hF0F0, 16'hFF00, 1'b1, 16'h0F0F, 1'b0};
      tv[10] = '{3'd6, 16'h8001, 16'h1234, 1'b1, 16'h0003, 1'b1};
      tv[11] = '{3'd7, 16'h8001, 16'h1234, 1'b1, 16'hC000, 1'b1};
      tv[12] = '{3'd6, 16'h4000, 16'h0000, 1'b0, 16'h8000, 1'b0};
      tv[13] = '{3'd7, 16'h0002, 16'h0000, 1'b0, 16'h0001, 1'b0};
      tv[14] = '{3'd1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tv[15] = '{3'd0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};

      // Reset with arbitrary inputs
      drive(1'b1, 3'd0, 16'hFFFF, 16'hFFFF, 1'b1);
      chk("reset_x", int'(x), 0);
      chk("reset_c", int'(c_out), 0);
`ifdef ALU16_FLAGS_EN
      chk("reset_z", int'(z), 0);
      chk("reset_v", int'(v), 0);
`endif

      // Directed table, back-to-back with a new Mode every cycle
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, tv[i].m, tv[i].a, tv[i].b, tv[i].ci);
         chk($sformatf("vec%0d_x", i), int'(x), int'(tv[i].x));
         chk($sformatf("vec%0d_c", i), int'(c_out), int'(tv[i].c));
      end

      // Mid-stream reset during an ADD discards it
      drive(1'b0, 3'd0, 16'h1111, 16'h2222, 1'b1);
      chk("pre_rst_x", int'(x), 16'h3334);
      drive(1'b1, 3'd0, 16'hFFFF, 16'h0001, 1'b0);
      chk("mid_rst_x", int'(x), 0);
      chk("mid_rst_c", int'(c_out), 0);
      drive(1'b0, 3'd6, 16'h8000, 16'h0000, 1'b0);
      chk("post_rst_x", int'(x), 0);
      chk("post_rst_c", int'(c_out), 1);

`ifdef ALU16_FLAGS_EN
      drive(1'b0, 3'd0, 16'h7FFF, 16'h0001, 1'b0);
      chk("flag_add_v", int'(v), 1);
      chk("flag_add_z", int'(z), 0);
      drive(1'b0, 3'd1, 16'h1234, 16'h1234, 1'b0);
      chk("flag_sub_z", int'(z), 1);
      chk("flag_sub_v", int'(v), 0);
      drive(1'b0, 3'd2, 16'h8000, 16'h8000, 1'b0);
      chk("flag_and_v", int'(v), 0);
`endif

      // Random ops with occasional reset
      for (int i = 0; i < 400; i++) begin
         r_rand = ($urandom_range(0, 19) == 0);
         drive(r_rand, 3'($urandom_range(0, 7)), 16'($urandom),
               16'($urandom), 1'($urandom_range(0, 1)));
         model(mode, a, b, c_in, ex, ec, ez, ev);
         if (r_rand) begin
            ex = '0;
            ec = 1'b0;
            ez = 1'b0;
            ev = 1'b0;
         end
         chk($sformatf("rnd%0d_x m=%0d", i, mode), int'(x), int'(ex));
         chk($sformatf("rnd%0d_c m=%0d", i, mode), int'(c_out), int'(ec));
`ifdef ALU16_FLAGS_EN
         chk($sformatf("rnd%0d_z", i), int'(z), int'(ez));
         chk($sformatf("rnd%0d_v", i), int'(v), int'(ev));
`endif
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
